// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access controller.
// Holds the memory op encoding, access size / sign decode helpers,
// exception codes and the controller FSM state type.
package dm_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_LWU = 4'd5,
        OP_SB  = 4'd6,
        OP_SH  = 4'd7,
        OP_SW  = 4'd8,
        OP_LD  = 4'd9,
        OP_SD  = 4'd10
    } mem_op_e;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // log2 of the access size in bytes: 0 byte, 1 half, 2 word, 3 dword
    function automatic logic [1:0] op_size_log2(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size_log2 = 2'd0;
            OP_LH, OP_LHU, OP_SH: op_size_log2 = 2'd1;
            OP_LW, OP_LWU, OP_SW: op_size_log2 = 2'd2;
            default:              op_size_log2 = 2'd3;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SD);
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        op_is_signed = (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
    endfunction

    // Doubleword and unsigned-word ops only exist on a 64-bit bus
    function automatic logic op_is_legal(input logic [3:0] op, input logic wide);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
            OP_SB, OP_SH, OP_SW:  op_is_legal = 1'b1;
            OP_LWU, OP_LD, OP_SD: op_is_legal = wide;
            default:              op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane alignment for one direction of the data bus.
// Ports:
//   op       in   memory op (selects access size and sign)
//   off      in   byte offset of the access inside the bus word
//   data_in  in   store operand (store path) or raw bus read data (load path)
//   byteen   out  byte enables for the access
//   data_out out  lane-shifted store data, or shifted-down and extended load data
// LOAD_PATH selects which transform drives data_out.
module dm_lane_align
    import dm_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter bit LOAD_PATH = 1'b0
) (
    input  logic [3:0]                 op,
    input  logic [$clog2(DATA_W/8)-1:0] off,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W/8-1:0]        byteen,
    output logic [DATA_W-1:0]          data_out
);

    localparam int NB = DATA_W / 8;

    logic [1:0]        size_log2;
    logic [NB-1:0]     be_base;
    logic [DATA_W-1:0] size_mask;

    assign size_log2 = op_size_log2(op);

    always_comb begin
        case (size_log2)
            2'd0: begin
                be_base   = NB'(1);
                size_mask = DATA_W'(64'h0000_0000_0000_00FF);
            end
            2'd1: begin
                be_base   = NB'(3);
                size_mask = DATA_W'(64'h0000_0000_0000_FFFF);
            end
            2'd2: begin
                be_base   = NB'(15);
                size_mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
            end
            default: begin
                be_base   = '1;
                size_mask = '1;
            end
        endcase
    end

    assign byteen = be_base << off;

    generate
        if (LOAD_PATH) begin : g_load
            logic [DATA_W-1:0] shifted;
            logic              sign_bit;

            assign shifted = data_in >> {off, 3'b000};

            always_comb begin
                case (size_log2)
                    2'd0:    sign_bit = shifted[7];
                    2'd1:    sign_bit = shifted[15];
                    2'd2:    sign_bit = shifted[31];
                    default: sign_bit = shifted[DATA_W-1];
                endcase
            end

            // Bits above the access size become copies of its top bit for
            // signed loads, zero otherwise; full-width accesses pass through.
            assign data_out = (shifted & size_mask)
                            | ((op_is_signed(op) && sign_bit) ? ~size_mask : '0);
        end else begin : g_store
            // Trim the operand to the access size before moving it to its lanes
            assign data_out = (data_in & size_mask) << {off, 3'b000};
        end
    endgenerate

endmodule

// File: rtl/dm_bus_ctrl.sv
// Data-memory access controller for the M stage.
// Checks alignment, runs one request/acknowledge bus transaction per
// aligned access, stalls the pipeline while it is outstanding and returns
// extended load data or an exception (AdEL / AdES / DBE).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/op/addr/wdata         M-stage memory request
//   stall                           freeze F/D/E/M stages
//   rsp_valid/rsp_rdata/exc/exc_code response to the pipeline
//   bus_req/we/addr/byteen/wdata    bus request fields
//   bus_ack/bus_rdata               bus completion and read data
module dm_bus_ctrl
    import dm_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [3:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                stall,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                exc,
    output logic [4:0]          exc_code,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_byteen,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int   NB    = DATA_W / 8;
    localparam int   OFF_W = $clog2(NB);
    localparam int   CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic WIDE  = (DATA_W == 64);

    state_e            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [3:0]        op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [NB-1:0]     be_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [OFF_W-1:0]  off_reg;
    logic              dbe_reg;

    logic [OFF_W-1:0]  req_off;
    logic [2:0]        align_mask;
    logic              req_legal;
    logic              req_misaligned;
    logic              req_accept;
    logic              timeout_hit;
    logic [NB-1:0]     st_be;
    logic [DATA_W-1:0] st_data;
    logic [NB-1:0]     ld_be_unused;
    logic [DATA_W-1:0] ld_data;

    assign req_off = req_addr[OFF_W-1:0];

    always_comb begin
        case (op_size_log2(req_op))
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    end

    assign req_legal      = op_is_legal(req_op, WIDE);
    assign req_misaligned = (req_addr[2:0] & align_mask) != 3'b000;
    assign req_accept     = (state_reg == ST_IDLE) && req_valid && req_legal && !req_misaligned;
    assign timeout_hit    = (cnt_reg == CNT_W'(TIMEOUT - 1));

    dm_lane_align #(.DATA_W(DATA_W), .LOAD_PATH(1'b0)) u_store_align (
        .op       (req_op),
        .off      (req_off),
        .data_in  (req_wdata),
        .byteen   (st_be),
        .data_out (st_data)
    );

    dm_lane_align #(.DATA_W(DATA_W), .LOAD_PATH(1'b1)) u_load_align (
        .op       (op_reg),
        .off      (off_reg),
        .data_in  (rdata_reg),
        .byteen   (ld_be_unused),
        .data_out (ld_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; an ack in the timeout cycle takes precedence
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (req_accept) state_next = ST_BUSY;
            ST_BUSY: if (bus_ack || timeout_hit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Transaction registers: request fields latched on accept, read data
    // captured on ack, error flag set when the wait budget runs out.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg   <= '0;
            op_reg    <= '0;
            addr_reg  <= '0;
            be_reg    <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            off_reg   <= '0;
            dbe_reg   <= 1'b0;
        end else begin
            if (req_accept) begin
                op_reg    <= req_op;
                addr_reg  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                be_reg    <= st_be;
                wdata_reg <= st_data;
                off_reg   <= req_off;
                cnt_reg   <= '0;
                dbe_reg   <= 1'b0;
            end
            if (state_reg == ST_BUSY) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
                if (bus_ack) begin
                    rdata_reg <= bus_rdata;
                end else if (timeout_hit) begin
                    dbe_reg <= 1'b1;
                end
            end
        end
    end

    // Output logic
    always_comb begin
        stall      = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        exc        = 1'b0;
        exc_code   = '0;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_byteen = '0;
        bus_wdata  = '0;
        case (state_reg)
            ST_IDLE: begin
                // Misalignment is reported in the same cycle without stalling
                if (req_valid && req_legal && req_misaligned) begin
                    rsp_valid = 1'b1;
                    exc       = 1'b1;
                    exc_code  = op_is_store(req_op) ? EXC_ADES : EXC_ADEL;
                end
                stall = req_accept;
            end
            ST_BUSY: begin
                stall      = 1'b1;
                bus_req    = 1'b1;
                bus_we     = op_is_store(op_reg);
                bus_addr   = addr_reg;
                bus_byteen = be_reg;
                bus_wdata  = wdata_reg;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (dbe_reg) begin
                    exc      = 1'b1;
                    exc_code = EXC_DBE;
                end else if (!op_is_store(op_reg)) begin
                    rsp_rdata = ld_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dm_bus_ctrl.sv
// Directed bench for dm_bus_ctrl: one 32-bit instance (TIMEOUT 4) and one
// 64-bit instance (TIMEOUT 16). Each access is described at transaction
// level; the bench derives the expected cycle-by-cycle outputs from the
// size/alignment/extension rules and a single process compares them.
module tb_dm_bus_ctrl;
    import dm_pkg::*;

    localparam int TO32 = 4;
    localparam int TO64 = 16;

    typedef struct packed {
        logic        stall;
        logic        rsp_valid;
        logic [63:0] rdata;
        logic        exc;
        logic [4:0]  code;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid [2];
    logic [3:0]  in_op    [2];
    logic [31:0] in_addr  [2];
    logic        in_ack   [2];
    logic [31:0] wd32, rd32;
    logic [63:0] wd64, rd64;

    logic        s32_stall, s32_rv, s32_exc, s32_req, s32_we;
    logic [31:0] s32_rdata, s32_addr, s32_wdata;
    logic [4:0]  s32_code;
    logic [3:0]  s32_be;
    logic        s64_stall, s64_rv, s64_exc, s64_req, s64_we;
    logic [63:0] s64_rdata, s64_wdata;
    logic [31:0] s64_addr;
    logic [4:0]  s64_code;
    logic [7:0]  s64_be;

    obs_t act [2];
    obs_t exp_o [2];
    bit   strict [2];
    bit   check_en = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] last_rdata [2];
    logic [4:0]  last_code  [2];
    logic [31:0] last_addr  [2];
    logic [7:0]  last_be    [2];
    logic [63:0] last_wdata [2];
    logic        last_we    [2];

    dm_bus_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO32)) dut32 (
        .clk(clk), .reset(reset),
        .req_valid(in_valid[0]), .req_op(in_op[0]), .req_addr(in_addr[0]), .req_wdata(wd32),
        .stall(s32_stall), .rsp_valid(s32_rv), .rsp_rdata(s32_rdata),
        .exc(s32_exc), .exc_code(s32_code),
        .bus_req(s32_req), .bus_we(s32_we), .bus_addr(s32_addr),
        .bus_byteen(s32_be), .bus_wdata(s32_wdata),
        .bus_ack(in_ack[0]), .bus_rdata(rd32)
    );

    dm_bus_ctrl #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO64)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(in_valid[1]), .req_op(in_op[1]), .req_addr(in_addr[1]), .req_wdata(wd64),
        .stall(s64_stall), .rsp_valid(s64_rv), .rsp_rdata(s64_rdata),
        .exc(s64_exc), .exc_code(s64_code),
        .bus_req(s64_req), .bus_we(s64_we), .bus_addr(s64_addr),
        .bus_byteen(s64_be), .bus_wdata(s64_wdata),
        .bus_ack(in_ack[1]), .bus_rdata(rd64)
    );

    always_comb begin
        act[0] = '{stall: s32_stall, rsp_valid: s32_rv, rdata: {32'h0, s32_rdata},
                   exc: s32_exc, code: s32_code, req: s32_req, we: s32_we,
                   addr: s32_addr, be: {4'h0, s32_be}, wdata: {32'h0, s32_wdata}};
        act[1] = '{stall: s64_stall, rsp_valid: s64_rv, rdata: s64_rdata,
                   exc: s64_exc, code: s64_code, req: s64_req, we: s64_we,
                   addr: s64_addr, be: s64_be, wdata: s64_wdata};
    end

    // ---------------- reference rules ----------------
    function automatic int m_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_LWU, OP_SW: return 4;
            default:              return 8;
        endcase
    endfunction

    function automatic bit m_legal(input logic [3:0] op, input int dw);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW: return 1'b1;
            OP_LWU, OP_LD, OP_SD: return dw == 64;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_store(input logic [3:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW || op == OP_SD;
    endfunction

    function automatic bit m_signed(input logic [3:0] op);
        return op == OP_LB || op == OP_LH || op == OP_LW;
    endfunction

    function automatic logic [7:0] m_be(input logic [3:0] op, input logic [31:0] addr, input int dw);
        int off = int'(addr % (dw / 8));
        return 8'(((1 << m_size(op)) - 1) << off);
    endfunction

    function automatic logic [63:0] m_wdata(input logic [3:0] op, input logic [31:0] addr,
                                            input logic [63:0] wdata, input int dw);
        int off = int'(addr % (dw / 8));
        logic [127:0] v = {64'h0, wdata};
        v = v % (128'(1) << (8 * m_size(op)));
        v = v << (8 * off);
        v = v % (128'(1) << dw);
        return v[63:0];
    endfunction

    function automatic logic [63:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [63:0] rdata, input int dw);
        int off = int'(addr % (dw / 8));
        logic [127:0] lim = 128'(1) << (8 * m_size(op));
        logic [127:0] v = {64'h0, rdata} >> (8 * off);
        v = v % lim;
        if (m_signed(op) && v >= lim / 2) v = v + (128'(1) << dw) - lim;
        v = v % (128'(1) << dw);
        return v[63:0];
    endfunction

    // ---------------- comparison ----------------
    task automatic chk(input string name, input int d, input logic [63:0] a, input logic [63:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s dut%0d @%0t: got %h, expected %h", name, d, $time, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("stall", d, 64'(act[d].stall), 64'(exp_o[d].stall));
                chk("rsp_valid", d, 64'(act[d].rsp_valid), 64'(exp_o[d].rsp_valid));
                chk("bus_req", d, 64'(act[d].req), 64'(exp_o[d].req));
                if (exp_o[d].rsp_valid || strict[d]) begin
                    chk("rsp_rdata", d, act[d].rdata, exp_o[d].rdata);
                    chk("exc", d, 64'(act[d].exc), 64'(exp_o[d].exc));
                    chk("exc_code", d, 64'(act[d].code), 64'(exp_o[d].code));
                end
                if (exp_o[d].req || strict[d]) begin
                    chk("bus_we", d, 64'(act[d].we), 64'(exp_o[d].we));
                    chk("bus_addr", d, 64'(act[d].addr), 64'(exp_o[d].addr));
                end
                if (exp_o[d].we || strict[d]) begin
                    chk("bus_byteen", d, 64'(act[d].be), 64'(exp_o[d].be));
                    chk("bus_wdata", d, act[d].wdata, exp_o[d].wdata);
                end
                if (act[d].rsp_valid) begin
                    last_rdata[d] = act[d].rdata;
                    last_code[d]  = act[d].code;
                end
                if (act[d].req) begin
                    last_addr[d]  = act[d].addr;
                    last_be[d]    = act[d].be;
                    last_wdata[d] = act[d].wdata;
                    last_we[d]    = act[d].we;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_cycle();
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            in_op[d]    = 4'hF;
            in_addr[d]  = 32'h0;
            in_ack[d]   = 1'b0;
            exp_o[d]    = '0;
            strict[d]   = 1'b0;
        end
        wd32 = 32'h0; wd64 = 64'h0;
        rd32 = 32'h0; rd64 = 64'h0;
    endtask

    task automatic set_req(input int d, input logic [3:0] op, input logic [31:0] addr,
                           input logic [63:0] wdata);
        in_valid[d] = 1'b1;
        in_op[d]    = op;
        in_addr[d]  = addr;
        if (d == 0) wd32 = wdata[31:0];
        else        wd64 = wdata;
    endtask

    task automatic set_bus(input int d, input logic ack, input logic [63:0] rdata);
        in_ack[d] = ack;
        if (d == 0) rd32 = rdata[31:0];
        else        rd64 = rdata;
    endtask

    task automatic exp_busy(input int d, input logic [3:0] op, input logic [31:0] addr,
                            input logic [63:0] wdata);
        int dw = (d == 0) ? 32 : 64;
        exp_o[d].stall = 1'b1;
        exp_o[d].req   = 1'b1;
        exp_o[d].we    = m_store(op);
        exp_o[d].addr  = addr - (addr % (dw / 8));
        exp_o[d].be    = m_be(op, addr, dw);
        exp_o[d].wdata = m_wdata(op, addr, wdata, dw);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            clear_cycle();
        end
    endtask

    // One access; w = number of BUSY cycles before ack (w >= timeout: never acked)
    task automatic do_access(input int d, input logic [3:0] op, input logic [31:0] addr,
                             input logic [63:0] wdata, input logic [63:0] rdata, input int w);
        int  dw = (d == 0) ? 32 : 64;
        int  to = (d == 0) ? TO32 : TO64;
        bit  legal = m_legal(op, dw);
        bit  aligned = (addr % m_size(op)) == 0;
        int  nbusy = (w < to) ? w + 1 : to;
        @(posedge clk); #1;
        clear_cycle();
        set_req(d, op, addr, wdata);
        if (legal && !aligned) begin
            exp_o[d].rsp_valid = 1'b1;
            exp_o[d].exc       = 1'b1;
            exp_o[d].code      = m_store(op) ? 5'd5 : 5'd4;
        end else if (legal) begin
            exp_o[d].stall = 1'b1;
        end
        if (!legal || !aligned) return;
        for (int k = 0; k < nbusy; k++) begin
            @(posedge clk); #1;
            clear_cycle();
            set_req(d, op, addr, wdata);
            set_bus(d, k == w, (k == w) ? rdata : ~rdata);
            exp_busy(d, op, addr, wdata);
        end
        @(posedge clk); #1;
        clear_cycle();
        set_req(d, op, addr, wdata);
        exp_o[d].rsp_valid = 1'b1;
        if (w >= to) begin
            exp_o[d].exc  = 1'b1;
            exp_o[d].code = 5'd7;
        end else if (!m_store(op)) begin
            exp_o[d].rdata = m_load(op, addr, rdata, dw);
        end
    endtask

    // ---------------- scenarios ----------------
    initial begin
        clear_cycle();
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            clear_cycle();
            reset = 1'b1;
            strict[0] = 1'b1;
            strict[1] = 1'b1;
            check_en = 1'b1;
        end
        idle(1);

        // Sign-extended byte load, ack in first BUSY cycle
        do_access(0, OP_LB, 32'h1003, 64'h0, 64'h80FF_0000, 0);
        idle(1);
        chk("lb_rdata_lit", 0, last_rdata[0], 64'hFFFF_FF80);

        // Half store with one wait cycle
        do_access(0, OP_SH, 32'h2002, 64'h1234_ABCD, 64'h0, 1);
        idle(1);
        chk("sh_be_lit", 0, 64'(last_be[0]), 64'h0C);
        chk("sh_wdata_lit", 0, last_wdata[0], 64'hABCD_0000);
        chk("sh_addr_lit", 0, 64'(last_addr[0]), 64'h2000);
        chk("sh_we_lit", 0, 64'(last_we[0]), 64'h1);

        // Misaligned load and store
        do_access(0, OP_LW, 32'h3002, 64'h0, 64'h0, 0);
        idle(1);
        chk("adel_code_lit", 0, 64'(last_code[0]), 64'd4);
        do_access(0, OP_SW, 32'h5002, 64'h55, 64'h0, 0);
        idle(1);
        chk("ades_code_lit", 0, 64'(last_code[0]), 64'd5);

        // Timeout: no ack, then ack in the last allowed BUSY cycle
        do_access(0, OP_LW, 32'h4000, 64'h0, 64'h0, 100);
        idle(1);
        chk("dbe_code_lit", 0, 64'(last_code[0]), 64'd7);
        do_access(0, OP_LW, 32'h4004, 64'h0, 64'hDEAD_BEEF, TO32 - 1);
        idle(1);
        chk("late_ack_lit", 0, last_rdata[0], 64'hDEAD_BEEF);

        // Extension variants, back-to-back with no idle gap
        do_access(0, OP_LHU, 32'h6002, 64'h0, 64'h8001_7777, 0);
        do_access(0, OP_LH,  32'h6002, 64'h0, 64'h8001_7777, 2);
        do_access(0, OP_LBU, 32'h6001, 64'h0, 64'h0000_F000, 0);
        do_access(0, OP_SB,  32'h6003, 64'h0000_01A5, 64'h0, 0);
        do_access(0, OP_SH,  32'h6000, 64'h1234_ABCD, 64'h0, 0);
        idle(1);
        // Doubleword op on the 32-bit bus is a no-op
        do_access(0, OP_LD, 32'h7000, 64'h0, 64'h0, 0);
        idle(1);

        // Reset during the second BUSY cycle, then a stray ack
        @(posedge clk); #1; clear_cycle();
        set_req(0, OP_LW, 32'h7000, 64'h0); exp_o[0].stall = 1'b1;
        @(posedge clk); #1; clear_cycle();
        set_req(0, OP_LW, 32'h7000, 64'h0); exp_busy(0, OP_LW, 32'h7000, 64'h0);
        @(posedge clk); #1; clear_cycle();
        set_req(0, OP_LW, 32'h7000, 64'h0); exp_busy(0, OP_LW, 32'h7000, 64'h0);
        reset = 1'b1;
        @(posedge clk); #1; clear_cycle();
        set_bus(0, 1'b1, 64'h1111_2222);
        strict[0] = 1'b1; strict[1] = 1'b1;
        @(posedge clk); #1; clear_cycle();
        strict[0] = 1'b1; strict[1] = 1'b1;
        idle(1);

        // 64-bit instance
        do_access(1, OP_LWU, 32'h0000_0104, 64'h0, 64'h8765_4321_0000_0000, 0);
        idle(1);
        chk("lwu_rdata_lit", 1, last_rdata[1], 64'h0000_0000_8765_4321);
        do_access(1, OP_SD, 32'h0000_0208, 64'h0123_4567_89AB_CDEF, 64'h0, 1);
        idle(1);
        chk("sd_be_lit", 1, 64'(last_be[1]), 64'hFF);
        do_access(1, OP_LW, 32'h0000_0104, 64'h0, 64'h8765_4321_0000_0000, 0);
        do_access(1, OP_LD, 32'h0000_0010, 64'h0, 64'hFEDC_BA98_7654_3210, 3);
        do_access(1, OP_LD, 32'h0000_0014, 64'h0, 64'h0, 0);
        do_access(1, OP_SB, 32'h0000_0305, 64'h0000_00AB, 64'h0, 0);
        do_access(1, OP_LH, 32'h0000_0306, 64'h8000_0000_0000_0000, 64'h0, 0);
        do_access(1, OP_LH, 32'h0000_0306, 64'h0, 64'h8000_0000_0000_0000, 0);
        idle(2);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
